// File: rtl/uart_debug_ctrl.sv
// uart_debug_ctrl
// Debug-unit controller sitting between the UART byte interface and the MIPS
// core. Decodes single-byte host commands, assembles instruction words from
// the RX stream and writes them to instruction memory, gates the core clock
// enable for run / single-step, and streams a debug dump back over UART TX
// with at most one byte in flight.
//
// Commands (accepted only while idle):
//   'L' 0x4C : load  -> count byte N (0 = 256), then N words, MSB-first; ACK 0x06
//   'R' 0x52 : run until i_cpu_halt, then dump
//   'S' 0x53 : single step (one enable cycle), then dump
//   'D' 0x44 : dump only
//   other    : NAK 0x15
//
// Ports:
//   i_clock, i_reset (async, active-low)
//   i_rx_done / i_rx_data           : received byte strobe and value
//   i_tx_done / i_tx_available      : TX byte finished / TX idle
//   o_tx_signal / o_tx_data         : TX start strobe and byte (held until i_tx_done)
//   o_imem_we / o_imem_addr / o_imem_data : instruction memory write port
//   o_cpu_enable / i_cpu_halt       : core clock enable and halt status
//   o_dump_idx / i_dump_data        : dump word select and combinational dump word
//   o_busy                          : controller not idle
module uart_debug_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int WORD_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int DUMP_WORDS = 33
) (
  input  logic                          i_clock,
  input  logic                          i_reset,
  input  logic                          i_rx_done,
  input  logic [DATA_WIDTH-1:0]         i_rx_data,
  input  logic                          i_tx_done,
  input  logic                          i_tx_available,
  output logic                          o_tx_signal,
  output logic [DATA_WIDTH-1:0]         o_tx_data,
  output logic                          o_imem_we,
  output logic [ADDR_WIDTH-1:0]         o_imem_addr,
  output logic [WORD_WIDTH-1:0]         o_imem_data,
  output logic                          o_cpu_enable,
  input  logic                          i_cpu_halt,
  output logic [$clog2(DUMP_WORDS)-1:0] o_dump_idx,
  input  logic [WORD_WIDTH-1:0]         i_dump_data,
  output logic                          o_busy
);

  localparam int BYTES  = WORD_WIDTH / DATA_WIDTH;
  localparam int BCNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int CNT_W  = DATA_WIDTH + 1;
  localparam int IDX_W  = $clog2(DUMP_WORDS);

  localparam logic [BCNT_W-1:0]     LAST_BYTE = BCNT_W'(BYTES - 1);
  localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(DUMP_WORDS - 1);
  localparam logic [CNT_W-1:0]      CNT_MAX   = CNT_W'(1) << DATA_WIDTH;

  localparam logic [DATA_WIDTH-1:0] CMD_LOAD = DATA_WIDTH'(8'h4C);
  localparam logic [DATA_WIDTH-1:0] CMD_RUN  = DATA_WIDTH'(8'h52);
  localparam logic [DATA_WIDTH-1:0] CMD_STEP = DATA_WIDTH'(8'h53);
  localparam logic [DATA_WIDTH-1:0] CMD_DUMP = DATA_WIDTH'(8'h44);
  localparam logic [DATA_WIDTH-1:0] RSP_ACK  = DATA_WIDTH'(8'h06);
  localparam logic [DATA_WIDTH-1:0] RSP_NAK  = DATA_WIDTH'(8'h15);

  typedef enum logic [3:0] {
    IDLE,
    LOAD_CNT,
    LOAD_BYTE,
    LOAD_WRITE,
    RUN,
    STEP,
    DUMP_LATCH,
    DUMP_SEND,
    DUMP_WAIT,
    SEND_RESP,
    WAIT_RESP
  } state_t;

  state_t                  state;
  logic [BCNT_W-1:0]       byte_cnt;
  logic [CNT_W-1:0]        word_cnt;
  logic [WORD_WIDTH-1:0]   shreg;

  // The assembled word doubles as the write-data register; it is only
  // meaningful while o_imem_we is high.
  assign o_imem_data = shreg;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state        <= IDLE;
      byte_cnt     <= '0;
      word_cnt     <= '0;
      shreg        <= '0;
      o_tx_signal  <= 1'b0;
      o_tx_data    <= '0;
      o_imem_we    <= 1'b0;
      o_imem_addr  <= '0;
      o_cpu_enable <= 1'b0;
      o_dump_idx   <= '0;
      o_busy       <= 1'b0;
    end else begin
      o_tx_signal <= 1'b0;
      o_imem_we   <= 1'b0;

      unique case (state)
        IDLE: begin
          if (i_rx_done) begin
            // Every byte received here leaves IDLE, so busy rises with it.
            o_busy <= 1'b1;
            case (i_rx_data)
              CMD_LOAD: state <= LOAD_CNT;
              CMD_RUN:  state <= RUN;
              CMD_STEP: begin
                state        <= STEP;
                o_cpu_enable <= 1'b1;
              end
              CMD_DUMP: state <= DUMP_LATCH;
              default: begin
                o_tx_data <= RSP_NAK;
                state     <= SEND_RESP;
              end
            endcase
          end
        end

        // ---- load: word count, byte assembly, memory write ----
        LOAD_CNT: begin
          if (i_rx_done) begin
            word_cnt    <= (i_rx_data == '0) ? CNT_MAX : CNT_W'(i_rx_data);
            o_imem_addr <= '0;
            byte_cnt    <= '0;
            state       <= LOAD_BYTE;
          end
        end

        LOAD_BYTE: begin
          if (i_rx_done) begin
            shreg <= {shreg[WORD_WIDTH-DATA_WIDTH-1:0], i_rx_data};
            if (byte_cnt == LAST_BYTE) begin
              byte_cnt  <= '0;
              o_imem_we <= 1'b1;
              state     <= LOAD_WRITE;
            end else begin
              byte_cnt <= byte_cnt + 1'b1;
            end
          end
        end

        LOAD_WRITE: begin
          o_imem_addr <= o_imem_addr + 1'b1;
          word_cnt    <= word_cnt - 1'b1;
          if (word_cnt == CNT_W'(1)) begin
            o_tx_data <= RSP_ACK;
            state     <= SEND_RESP;
          end else begin
            state <= LOAD_BYTE;
          end
        end

        // ---- execution gating ----
        RUN: begin
          // Halt is checked before enabling, so a core that is already
          // halted on entry never sees an enable cycle.
          if (i_cpu_halt) begin
            o_cpu_enable <= 1'b0;
            state        <= DUMP_LATCH;
          end else begin
            o_cpu_enable <= 1'b1;
          end
        end

        STEP: begin
          o_cpu_enable <= 1'b0;
          state        <= DUMP_LATCH;
        end

        // ---- dump: latch word, send bytes MSB-first ----
        DUMP_LATCH: begin
          shreg    <= i_dump_data;
          byte_cnt <= '0;
          state    <= DUMP_SEND;
        end

        DUMP_SEND: begin
          if (i_tx_available) begin
            o_tx_signal <= 1'b1;
            o_tx_data   <= shreg[WORD_WIDTH-1 -: DATA_WIDTH];
            state       <= DUMP_WAIT;
          end
        end

        DUMP_WAIT: begin
          if (i_tx_done) begin
            shreg <= shreg << DATA_WIDTH;
            if (byte_cnt != LAST_BYTE) begin
              byte_cnt <= byte_cnt + 1'b1;
              state    <= DUMP_SEND;
            end else if (o_dump_idx < LAST_IDX) begin
              o_dump_idx <= o_dump_idx + 1'b1;
              state      <= DUMP_LATCH;
            end else begin
              o_dump_idx <= '0;
              o_busy     <= 1'b0;
              state      <= IDLE;
            end
          end
        end

        // ---- single response byte (ACK / NAK already in o_tx_data) ----
        SEND_RESP: begin
          if (i_tx_available) begin
            o_tx_signal <= 1'b1;
            state       <= WAIT_RESP;
          end
        end

        WAIT_RESP: begin
          if (i_tx_done) begin
            o_busy <= 1'b0;
            state  <= IDLE;
          end
        end

        default: begin
          o_busy <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule
